// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_sel.sv
// Per-operand forwarding select: the younger EX/MEM result wins over MEM/WB,
// and register 0 is never forwarded.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_reg,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write_en,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write_en,
    output fwd_sel_t          sel
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_reg_write_en && (exmem_rd != REG_AW'(REG_ZERO)) && (exmem_rd == src_reg);
    assign memwb_hit = memwb_reg_write_en && (memwb_rd != REG_AW'(REG_ZERO)) && (memwb_rd == src_reg);

    always_comb begin
        sel = FWD_NONE;
        if (exmem_hit) begin
            sel = FWD_MEM;
        end else if (memwb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard unit: operand forwarding, load-use bubble, memory-busy freeze,
// stall counter and sticky memory-timeout flag. Option macro: STORE_DATA_FWD_EN.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ifid_rs1,
    input  logic [REG_AW-1:0] ifid_rs2,
    input  logic              ifid_uses_rs2,
    input  logic              ifid_is_store,
    input  logic [REG_AW-1:0] idex_rs1,
    input  logic [REG_AW-1:0] idex_rs2,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write_en,
    input  logic [REG_AW-1:0] exmem_rs2,
    input  logic              exmem_mem_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write_en,
    input  logic              memwb_mem_read,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              fwd_store_data,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              idex_flush,
    output logic              freeze,
    output logic [CNT_W-1:0]  stall_count,
    output logic              mem_timeout
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

    logic [REG_AW-1:0] idex_src [2];
    fwd_sel_t          sel_arr  [2];

    assign idex_src[0] = idex_rs1;
    assign idex_src[1] = idex_rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_sel #(
                .REG_AW(REG_AW)
            ) u_fwd_sel (
                .src_reg            (idex_src[gi]),
                .exmem_rd           (exmem_rd),
                .exmem_reg_write_en (exmem_reg_write_en),
                .memwb_rd           (memwb_rd),
                .memwb_reg_write_en (memwb_reg_write_en),
                .sel                (sel_arr[gi])
            );
        end
    endgenerate

    assign forward_a = sel_arr[0];
    assign forward_b = sel_arr[1];

    logic rs1_dep;
    logic rs2_dep;
    logic load_use;

    assign rs1_dep = idex_rd == ifid_rs1;

`ifdef STORE_DATA_FWD_EN
    // Store data of a dependent store is picked up later from WB, so only its base register stalls.
    assign rs2_dep        = ifid_uses_rs2 && !ifid_is_store && (idex_rd == ifid_rs2);
    assign fwd_store_data = exmem_mem_write && memwb_mem_read && memwb_reg_write_en &&
                            (memwb_rd != REG_AW'(REG_ZERO)) && (memwb_rd == exmem_rs2);
`else
    logic unused_store_fwd;
    assign unused_store_fwd = ^{ifid_is_store, exmem_rs2, exmem_mem_write, memwb_mem_read};
    assign rs2_dep          = ifid_uses_rs2 && (idex_rd == ifid_rs2);
    assign fwd_store_data   = 1'b0;
`endif

    assign load_use = idex_mem_read && (idex_rd != REG_AW'(REG_ZERO)) && (rs1_dep || rs2_dep);

    // A frozen pipeline must not also take a bubble, or the held instruction would be lost.
    assign freeze        = mem_req && !mem_ready;
    assign pc_write_en   = !(freeze || load_use);
    assign ifid_write_en = !(freeze || load_use);
    assign idex_flush    = load_use && !freeze;

    hz_state_t         state_reg,       state_next;
    logic [WAIT_W-1:0] wait_cnt_reg,    wait_cnt_next;
    logic              mem_timeout_reg, mem_timeout_next;
    logic [CNT_W-1:0]  stall_cnt_reg,   stall_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
            stall_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
            stall_cnt_reg   <= stall_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        mem_timeout_next = mem_timeout_reg;
        stall_cnt_next   = stall_cnt_reg;

        case (state_reg)
            RUN: begin
                if (freeze) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next = RUN;
                end else begin
                    // Counter parks at the limit so it cannot wrap back below it.
                    if (wait_cnt_reg < WAIT_W'(MEM_TIMEOUT)) begin
                        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                    end
                    if ((MEM_TIMEOUT != 0) && (wait_cnt_next == WAIT_W'(MEM_TIMEOUT))) begin
                        mem_timeout_next = 1'b1;
                    end
                end
            end
            default: state_next = RUN;
        endcase

        if ((freeze || load_use) && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_count = stall_cnt_reg;
    assign mem_timeout = mem_timeout_reg;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: combinational vector table plus
// clocked sequences for stall counting, freeze, timeout and store forwarding.
module tb_hazard_forward_ctrl;

`ifdef STORE_DATA_FWD_EN
    localparam bit SDF = 1'b1;
`else
    localparam bit SDF = 1'b0;
`endif

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd;
    logic [4:0]       exmem_rd, exmem_rs2, memwb_rd;
    logic             ifid_uses_rs2, ifid_is_store, idex_mem_read;
    logic             exmem_reg_write_en, exmem_mem_write;
    logic             memwb_reg_write_en, memwb_mem_read, mem_req, mem_ready;
    logic [1:0]       forward_a, forward_b;
    logic             fwd_store_data, pc_write_en, ifid_write_en, idex_flush, freeze;
    logic [CNT_W-1:0] stall_count;
    logic             mem_timeout;

    int checks = 0;
    int errors = 0;
    int exp_sc;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(
        .REG_AW(5), .CNT_W(CNT_W), .MEM_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_uses_rs2(ifid_uses_rs2), .ifid_is_store(ifid_is_store),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_mem_read(idex_mem_read),
        .exmem_rd(exmem_rd), .exmem_reg_write_en(exmem_reg_write_en),
        .exmem_rs2(exmem_rs2), .exmem_mem_write(exmem_mem_write),
        .memwb_rd(memwb_rd), .memwb_reg_write_en(memwb_reg_write_en),
        .memwb_mem_read(memwb_mem_read),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .forward_a(forward_a), .forward_b(forward_b),
        .fwd_store_data(fwd_store_data), .pc_write_en(pc_write_en),
        .ifid_write_en(ifid_write_en), .idex_flush(idex_flush),
        .freeze(freeze), .stall_count(stall_count), .mem_timeout(mem_timeout)
    );

    typedef struct packed {
        logic [4:0] r1, r2;  logic u2, st;
        logic [4:0] x1, x2, xrd; logic xmr;
        logic [4:0] mrd; logic mwe; logic [4:0] mrs2; logic mmw;
        logic [4:0] wrd; logic wwe, wmr;
        logic req, rdy;
        logic [1:0] fa, fb; logic fsd, pc, ifid, fl, fz;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_inputs();
        ifid_rs1 = 0; ifid_rs2 = 0; ifid_uses_rs2 = 0; ifid_is_store = 0;
        idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0; idex_mem_read = 0;
        exmem_rd = 0; exmem_reg_write_en = 0; exmem_rs2 = 0; exmem_mem_write = 0;
        memwb_rd = 0; memwb_reg_write_en = 0; memwb_mem_read = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // order: r1 r2 u2 st | x1 x2 xrd xmr | mrd mwe mrs2 mmw | wrd wwe wmr | req rdy || fa fb fsd pc ifid fl fz
        tbl[0]  = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0,0,1,1,0,0};
        tbl[1]  = '{0,0,0,0, 5,0,0,0, 5,1,0,0, 5,1,0, 0,0, 2,0,0,1,1,0,0};
        tbl[2]  = '{0,0,0,0, 0,0,0,0, 0,1,0,0, 0,1,0, 0,0, 0,0,0,1,1,0,0};
        tbl[3]  = '{0,0,0,0, 4,9,0,0, 4,1,0,0, 9,1,0, 0,0, 2,1,0,1,1,0,0};
        tbl[4]  = '{0,0,0,0, 6,6,0,0, 6,0,0,0, 6,1,0, 0,0, 1,1,0,1,1,0,0};
        tbl[5]  = '{0,0,0,0, 6,6,0,0, 6,0,0,0, 6,0,0, 0,0, 0,0,0,1,1,0,0};
        tbl[6]  = '{7,0,0,0, 0,0,7,1, 0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,1,0};
        tbl[7]  = '{0,7,0,0, 0,0,7,1, 0,0,0,0, 0,0,0, 0,0, 0,0,0,1,1,0,0};
        tbl[8]  = '{0,7,1,0, 0,0,7,1, 0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,1,0};
        tbl[9]  = '{0,0,1,0, 0,0,0,1, 0,0,0,0, 0,0,0, 0,0, 0,0,0,1,1,0,0};
        tbl[10] = '{7,0,0,0, 0,0,7,1, 0,0,0,0, 0,0,0, 1,0, 0,0,0,0,0,0,1};
        tbl[11] = '{7,0,0,0, 0,0,7,1, 0,0,0,0, 0,0,0, 1,1, 0,0,0,0,0,1,0};
        tbl[12] = '{2,3,1,1, 0,0,3,1, 0,0,0,0, 0,0,0, 0,0, 0,0,0,SDF,SDF,!SDF,0};
        tbl[13] = '{3,3,1,1, 0,0,3,1, 0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,1,0};
        tbl[14] = '{0,0,0,0, 0,0,0,0, 0,0,3,1, 3,1,1, 0,0, 0,0,SDF,1,1,0,0};
        tbl[15] = '{0,0,0,0, 0,0,0,0, 0,0,0,1, 0,1,1, 0,0, 0,0,0,1,1,0,0};
        tbl[16] = '{0,0,0,0, 0,0,0,0, 0,0,3,1, 3,1,0, 0,0, 0,0,0,1,1,0,0};
        tbl[17] = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,0, 0,0,0,0,0,0,1};

        clr_inputs();
        rst_n = 1'b0;
        #1;
        chk("reset.stall_count", int'(stall_count), 0);
        chk("reset.mem_timeout", int'(mem_timeout), 0);
        chk("reset.pc_write_en", int'(pc_write_en), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            ifid_rs1 = tbl[i].r1; ifid_rs2 = tbl[i].r2;
            ifid_uses_rs2 = tbl[i].u2; ifid_is_store = tbl[i].st;
            idex_rs1 = tbl[i].x1; idex_rs2 = tbl[i].x2;
            idex_rd = tbl[i].xrd; idex_mem_read = tbl[i].xmr;
            exmem_rd = tbl[i].mrd; exmem_reg_write_en = tbl[i].mwe;
            exmem_rs2 = tbl[i].mrs2; exmem_mem_write = tbl[i].mmw;
            memwb_rd = tbl[i].wrd; memwb_reg_write_en = tbl[i].wwe;
            memwb_mem_read = tbl[i].wmr;
            mem_req = tbl[i].req; mem_ready = tbl[i].rdy;
            #1;
            $display("vec %0d: fa=%0d fb=%0d fsd=%0d pc=%0d ifid=%0d flush=%0d freeze=%0d", i,
                     forward_a, forward_b, fwd_store_data, pc_write_en, ifid_write_en, idex_flush, freeze);
            chk($sformatf("v%0d.forward_a", i), int'(forward_a), int'(tbl[i].fa));
            chk($sformatf("v%0d.forward_b", i), int'(forward_b), int'(tbl[i].fb));
            chk($sformatf("v%0d.fwd_store_data", i), int'(fwd_store_data), int'(tbl[i].fsd));
            chk($sformatf("v%0d.pc_write_en", i), int'(pc_write_en), int'(tbl[i].pc));
            chk($sformatf("v%0d.ifid_write_en", i), int'(ifid_write_en), int'(tbl[i].ifid));
            chk($sformatf("v%0d.idex_flush", i), int'(idex_flush), int'(tbl[i].fl));
            chk($sformatf("v%0d.freeze", i), int'(freeze), int'(tbl[i].fz));
        end

        // Clean restart for the clocked sequences.
        clr_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2.stall_count", int'(stall_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_sc = 0;

        // Load-use: exactly one bubble cycle.
        idex_mem_read = 1; idex_rd = 7; ifid_rs1 = 7;
        #1;
        chk("lu.pc_write_en", int'(pc_write_en), 0);
        chk("lu.idex_flush", int'(idex_flush), 1);
        cyc(); exp_sc++;
        $display("seq lu: stall_count=%0d", stall_count);
        chk("lu.stall_count", int'(stall_count), exp_sc);
        idex_mem_read = 0; idex_rd = 0;
        #1;
        chk("lu_after.pc_write_en", int'(pc_write_en), 1);
        cyc();
        chk("lu_after.stall_count", int'(stall_count), exp_sc);

        // Freeze for three cycles, then memory completes.
        clr_inputs();
        mem_req = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("frz%0d.freeze", k), int'(freeze), 1);
            cyc(); exp_sc++;
        end
        mem_ready = 1;
        #1;
        chk("frz_done.freeze", int'(freeze), 0);
        cyc();
        $display("seq freeze: stall_count=%0d mem_timeout=%0d", stall_count, mem_timeout);
        chk("frz_done.stall_count", int'(stall_count), exp_sc);
        chk("frz_done.mem_timeout", int'(mem_timeout), 0);

        // Timeout: limit of 4 consecutive wait cycles.
        mem_ready = 0;
        cyc(); exp_sc++;
        for (int k = 1; k <= 3; k++) begin
            cyc(); exp_sc++;
            chk($sformatf("to_wait%0d.mem_timeout", k), int'(mem_timeout), 0);
        end
        cyc(); exp_sc++;
        $display("seq timeout: mem_timeout=%0d stall_count=%0d", mem_timeout, stall_count);
        chk("to_hit.mem_timeout", int'(mem_timeout), 1);
        chk("to_hit.stall_count", int'(stall_count), exp_sc);
        mem_ready = 1;
        cyc();
        mem_req = 0; mem_ready = 0;
        cyc(); cyc();
        chk("to_sticky.mem_timeout", int'(mem_timeout), 1);

        // Counter saturates instead of wrapping.
        mem_req = 1;
        for (int k = 0; k < 10; k++) cyc();
        $display("seq saturate: stall_count=%0d", stall_count);
        chk("sat.stall_count", int'(stall_count), (1 << CNT_W) - 1);

        // Asynchronous reset in the middle of a freeze.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.stall_count", int'(stall_count), 0);
        chk("midrst.mem_timeout", int'(mem_timeout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("midrst_run.stall_count", int'(stall_count), 1);
        exp_sc = 1;
        mem_ready = 1;
        cyc();
        clr_inputs();

        // ld x3 followed by sd x3.
        ifid_rs1 = 2; ifid_rs2 = 3; ifid_uses_rs2 = 1; ifid_is_store = 1;
        idex_rd = 3; idex_mem_read = 1;
        #1;
        chk("ldst.pc_write_en", int'(pc_write_en), int'(SDF));
        chk("ldst.idex_flush", int'(idex_flush), int'(!SDF));
        cyc();
        if (!SDF) exp_sc++;
        chk("ldst.stall_count", int'(stall_count), exp_sc);
        clr_inputs();
        exmem_mem_write = 1; exmem_rs2 = 3;
        if (SDF) begin
            memwb_rd = 3; memwb_reg_write_en = 1; memwb_mem_read = 1;
        end
        #1;
        $display("seq ldst: fwd_store_data=%0d stall_count=%0d", fwd_store_data, stall_count);
        chk("ldst_mem.fwd_store_data", int'(fwd_store_data), int'(SDF));
        cyc();
        clr_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
